// File: rtl/riscv_retire_checker.sv
// Retirement checkpoint checker: a table of (instruction count, expected OUTPUT_PORT) pairs is
// loaded in IDLE, checked against the core in RUN, and the verdict is held with diagnostics.
module riscv_retire_checker #(
    parameter int unsigned NUM_TEST       = 17,
    parameter int unsigned IDX_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_WE,
    input  logic [IDX_W-1:0] CFG_ADDR,
    input  logic [31:0]      CFG_NUMINST,
    input  logic [31:0]      CFG_ANS,
    output logic             CFG_ERR,
    input  logic             START,
    input  logic [31:0]      NUM_INST,
    input  logic [31:0]      OUTPUT_PORT,
    input  logic             HALT,
    output logic             DONE,
    output logic             PASS,
    output logic [1:0]       FAIL_CODE,
    output logic             TIMEOUT,
    output logic [IDX_W-1:0] FAIL_IDX,
    output logic [31:0]      FAIL_GOT,
    output logic [31:0]      FAIL_EXP,
    output logic [IDX_W:0]   PASS_CNT,
    output logic [31:0]      CYCLE
);
    typedef enum logic [1:0] {IDLE, RUN, VERDICT} state_t;

    localparam logic [IDX_W:0] MAX_N   = (IDX_W+1)'(NUM_TEST);
    localparam logic [31:0]    TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [31:0]      tbl_num [NUM_TEST];
    logic [31:0]      tbl_ans [NUM_TEST];
    logic [IDX_W:0]   n, n_nxt;
    logic             cfg_err_nxt, done_nxt, pass_nxt, timeout_nxt;
    logic [1:0]       fail_code_nxt;
    logic [IDX_W-1:0] fail_idx_nxt;
    logic [31:0]      fail_got_nxt, fail_exp_nxt, cycle_nxt;
    logic [IDX_W:0]   ptr_nxt, ptr_post;
    logic [IDX_W-1:0] ptr_idx, post_idx, last_idx;
    logic             cfg_ok, cfg_wr, launch;
    logic             pending, at_ckpt, past_ckpt, advance, fail_ab;

    // PASS_CNT doubles as the checkpoint pointer: it only moves on a matched entry.
    always_comb begin
        ptr_idx   = PASS_CNT[IDX_W-1:0];
        pending   = PASS_CNT < n;
        at_ckpt   = pending && (NUM_INST == tbl_num[ptr_idx]);
        past_ckpt = pending && (NUM_INST > tbl_num[ptr_idx]);
        advance   = at_ckpt && (OUTPUT_PORT == tbl_ans[ptr_idx]);
        fail_ab   = (at_ckpt && !advance) || past_ckpt;
        ptr_post  = PASS_CNT + (IDX_W+1)'(advance);
        post_idx  = advance ? ptr_idx + IDX_W'(1) : ptr_idx;
        last_idx  = n[IDX_W-1:0] - IDX_W'(1);
        cfg_ok    = ({1'b0, CFG_ADDR} == n) && (n < MAX_N) &&
                    ((n == '0) || (CFG_NUMINST > tbl_num[last_idx]));
    end

    always_comb begin
        state_nxt     = state;
        n_nxt         = n;
        cfg_err_nxt   = CFG_ERR;
        ptr_nxt       = PASS_CNT;
        done_nxt      = DONE;
        pass_nxt      = PASS;
        fail_code_nxt = FAIL_CODE;
        timeout_nxt   = TIMEOUT;
        fail_idx_nxt  = FAIL_IDX;
        fail_got_nxt  = FAIL_GOT;
        fail_exp_nxt  = FAIL_EXP;
        cycle_nxt     = CYCLE;
        cfg_wr        = 1'b0;
        launch        = 1'b0;
        unique case (state)
            IDLE: begin
                if (CFG_WE) begin
                    if (cfg_ok) begin
                        cfg_wr      = 1'b1;
                        n_nxt       = n + (IDX_W+1)'(1);
                        cfg_err_nxt = 1'b0;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
                launch = START;
            end
            RUN: begin
                cycle_nxt = (CYCLE == '1) ? CYCLE : CYCLE + 32'd1;
                ptr_nxt   = ptr_post;
                if (fail_ab) begin
                    state_nxt     = VERDICT;
                    done_nxt      = 1'b1;
                    fail_code_nxt = at_ckpt ? 2'd1 : 2'd2;
                    fail_idx_nxt  = ptr_idx;
                    fail_got_nxt  = OUTPUT_PORT;
                    fail_exp_nxt  = tbl_ans[ptr_idx];
                end else if (HALT) begin
                    // HALT sees the pointer after this cycle's match, so a final match plus HALT passes
                    state_nxt = VERDICT;
                    done_nxt  = 1'b1;
                    if (ptr_post == n) begin
                        pass_nxt = 1'b1;
                    end else begin
                        fail_code_nxt = 2'd3;
                        fail_idx_nxt  = post_idx;
                        fail_got_nxt  = OUTPUT_PORT;
                        fail_exp_nxt  = tbl_ans[post_idx];
                    end
                end else if (CYCLE == TO_LAST) begin
                    state_nxt   = VERDICT;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                end
            end
            VERDICT: launch = START;
            default: state_nxt = IDLE;
        endcase
        if (launch) begin
            state_nxt     = RUN;
            ptr_nxt       = '0;
            cycle_nxt     = '0;
            done_nxt      = 1'b0;
            pass_nxt      = 1'b0;
            fail_code_nxt = '0;
            timeout_nxt   = 1'b0;
            fail_idx_nxt  = '0;
            fail_got_nxt  = '0;
            fail_exp_nxt  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            n         <= '0;
            CFG_ERR   <= 1'b0;
            PASS_CNT  <= '0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL_CODE <= '0;
            TIMEOUT   <= 1'b0;
            FAIL_IDX  <= '0;
            FAIL_GOT  <= '0;
            FAIL_EXP  <= '0;
            CYCLE     <= '0;
        end else begin
            state     <= state_nxt;
            n         <= n_nxt;
            CFG_ERR   <= cfg_err_nxt;
            PASS_CNT  <= ptr_nxt;
            DONE      <= done_nxt;
            PASS      <= pass_nxt;
            FAIL_CODE <= fail_code_nxt;
            TIMEOUT   <= timeout_nxt;
            FAIL_IDX  <= fail_idx_nxt;
            FAIL_GOT  <= fail_got_nxt;
            FAIL_EXP  <= fail_exp_nxt;
            CYCLE     <= cycle_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (cfg_wr) begin
            tbl_num[CFG_ADDR] <= CFG_NUMINST;
            tbl_ans[CFG_ADDR] <= CFG_ANS;
        end
    end

endmodule

// File: tb/tb_riscv_retire_checker.sv
`timescale 1ns/1ps
// Bench for riscv_retire_checker: directed checkpoint scenarios plus randomized tables and traces
// scored against a trace-walking reference model.
module tb_riscv_retire_checker;
    localparam int NT       = 17;
    localparam int IW       = 5;
    localparam int MAIN_TO  = 2000;
    localparam int SHORT_TO = 50;

    logic          CLK = 1'b0;
    logic          RST = 1'b0, CFG_WE = 1'b0, START = 1'b0, HALT = 1'b0;
    logic [IW-1:0] CFG_ADDR = '0;
    logic [31:0]   CFG_NUMINST = '0, CFG_ANS = '0, NUM_INST = '0, OUTPUT_PORT = '0;

    logic          d_cfg_err, d_done, d_pass, d_tmo, t_cfg_err, t_done, t_pass, t_tmo;
    logic [1:0]    d_code, t_code;
    logic [IW-1:0] d_idx, t_idx;
    logic [31:0]   d_got, d_exp, d_cyc, t_got, t_exp, t_cyc;
    logic [IW:0]   d_cnt, t_cnt;
    logic [111:0]  d_vec, t_vec;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] m_num [NT];
    logic [31:0] m_ans [NT];
    int          m_n = 0;
    logic [31:0] q_ni [$];
    logic [31:0] q_out [$];
    bit          q_halt [$];

    always #5 CLK = ~CLK;

    riscv_retire_checker #(.NUM_TEST(NT), .IDX_W(IW), .TIMEOUT_CYCLES(MAIN_TO)) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_NUMINST(CFG_NUMINST),
        .CFG_ANS(CFG_ANS), .CFG_ERR(d_cfg_err), .START(START), .NUM_INST(NUM_INST),
        .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .DONE(d_done), .PASS(d_pass), .FAIL_CODE(d_code),
        .TIMEOUT(d_tmo), .FAIL_IDX(d_idx), .FAIL_GOT(d_got), .FAIL_EXP(d_exp), .PASS_CNT(d_cnt),
        .CYCLE(d_cyc));

    riscv_retire_checker #(.NUM_TEST(NT), .IDX_W(IW), .TIMEOUT_CYCLES(SHORT_TO)) tdut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_NUMINST(CFG_NUMINST),
        .CFG_ANS(CFG_ANS), .CFG_ERR(t_cfg_err), .START(START), .NUM_INST(NUM_INST),
        .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .DONE(t_done), .PASS(t_pass), .FAIL_CODE(t_code),
        .TIMEOUT(t_tmo), .FAIL_IDX(t_idx), .FAIL_GOT(t_got), .FAIL_EXP(t_exp), .PASS_CNT(t_cnt),
        .CYCLE(t_cyc));

    assign d_vec = {d_done, d_pass, d_code, d_tmo, d_idx, d_got, d_exp, d_cnt, d_cyc};
    assign t_vec = {t_done, t_pass, t_code, t_tmo, t_idx, t_got, t_exp, t_cnt, t_cyc};

    // Expected {DONE,PASS,FAIL_CODE,TIMEOUT,FAIL_IDX,FAIL_GOT,FAIL_EXP,PASS_CNT,CYCLE} after the trace.
    function automatic logic [111:0] model(input int to);
        int          k = 0;
        logic        done = 1'b0, pass = 1'b0, tmo = 1'b0;
        logic [1:0]  code = '0;
        logic [4:0]  idx = '0;
        logic [31:0] got = '0, ex = '0, cyc = '0;
        for (int i = 0; i < q_ni.size() && !done; i++) begin
            cyc = 32'(i + 1);
            if (k < m_n && q_ni[i] == m_num[k]) begin
                if (q_out[i] == m_ans[k]) k++;
                else begin done = 1'b1; code = 2'd1; idx = 5'(k); got = q_out[i]; ex = m_ans[k]; end
            end else if (k < m_n && q_ni[i] > m_num[k]) begin
                done = 1'b1; code = 2'd2; idx = 5'(k); got = q_out[i]; ex = m_ans[k];
            end
            if (!done && q_halt[i]) begin
                done = 1'b1;
                if (k == m_n) pass = 1'b1;
                else begin code = 2'd3; idx = 5'(k); got = q_out[i]; ex = m_ans[k]; end
            end
            if (!done && i == to - 1) begin done = 1'b1; tmo = 1'b1; end
        end
        return {done, pass, code, tmo, idx, got, ex, 6'(k), cyc};
    endfunction

    task automatic do_reset();
        RST = 1'b1; CFG_WE = 1'b0; START = 1'b0; HALT = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] num, input logic [31:0] ans);
        CFG_WE = 1'b1; CFG_ADDR = IW'(addr); CFG_NUMINST = num; CFG_ANS = ans;
        @(posedge CLK); #1;
        CFG_WE = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < m_n; i++) cfg_write(i, m_num[i], m_ans[i]);
    endtask

    task automatic set_forloop();
        m_num = '{32'h04, 32'h06, 32'h08, 32'h0a, 32'h0c, 32'h0e, 32'h10, 32'h12, 32'h14,
                  32'h16, 32'h1e, 32'h26, 32'h2e, 32'h36, 32'h3e, 32'h42, 32'h46};
        m_ans = '{32'h0eec, 32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h3, 32'h3, 32'h4,
                  32'h4, 32'h2, 32'h1, 32'h3, 32'h0, 32'h5, 32'h6, 32'h0};
        m_n = NT;
    endtask

    task automatic q_clear();
        q_ni.delete(); q_out.delete(); q_halt.delete();
    endtask

    task automatic push(input logic [31:0] ni, input logic [31:0] o, input bit h);
        q_ni.push_back(ni); q_out.push_back(o); q_halt.push_back(h);
    endtask

    // mode 0 clean, 1 corrupt value at sel, 2 skip sel, 3 HALT at sel, 4 no HALT, 5 HALT before sel
    task automatic build_trace(input int mode, input int sel);
        logic [31:0] prev;
        int          fill;
        bit          h;
        prev = '0;
        q_clear();
        for (int c = 0; c < m_n; c++) begin
            fill = $urandom_range(0, 2);
            if (mode == 5 && c == sel && fill == 0) fill = 1;
            for (int f = 0; f < fill; f++) push(prev, $urandom, mode == 5 && c == sel && f == 0);
            if (mode == 2 && c == sel) continue;
            h = ((mode <= 2) && c == m_n - 1) || (mode == 3 && c == sel);
            push(m_num[c], (mode == 1 && c == sel) ? m_ans[c] ^ (32'd1 << $urandom_range(0, 31))
                                                   : m_ans[c], h);
            prev = m_num[c];
        end
    endtask

    task automatic drive_trace();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 0; i < q_ni.size(); i++) begin
            NUM_INST = q_ni[i]; OUTPUT_PORT = q_out[i]; HALT = q_halt[i];
            @(posedge CLK); #1;
            if (d_done) break;
        end
        HALT = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({d_cfg_err, d_vec} !== 113'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected 0", {d_cfg_err, d_vec});
        end
    endtask

    task automatic test_forloop_pass();
        logic [111:0] e;
        do_reset(); set_forloop(); load_table();
        build_trace(0, 0); drive_trace();
        e = model(MAIN_TO);
        compared++;
        if (d_vec !== e) begin
            mismatched++; $display("FAIL forloop_pass: got %h expected %h", d_vec, e);
        end
        compared++;
        if ({d_done, d_pass, d_code, d_cnt} !== {1'b1, 1'b1, 2'd0, 6'd17}) begin
            mismatched++;
            $display("FAIL forloop_pass_fields: got %h expected %h", {d_done, d_pass, d_code, d_cnt},
                     {1'b1, 1'b1, 2'd0, 6'd17});
        end
        // restart from the verdict with the table retained
        build_trace(1, $urandom_range(0, NT - 1)); drive_trace();
        e = model(MAIN_TO);
        compared++;
        if (d_vec !== e) begin
            mismatched++; $display("FAIL back_to_back: got %h expected %h", d_vec, e);
        end
    endtask

    task automatic test_value_mismatch();
        logic [111:0] e;
        do_reset(); set_forloop(); load_table();
        q_clear(); push(32'h4, 32'h0eed, 1'b0); drive_trace();
        e = model(MAIN_TO);
        compared++;
        if (d_vec !== e) begin
            mismatched++; $display("FAIL value_mismatch: got %h expected %h", d_vec, e);
        end
        compared++;
        if ({d_done, d_code, d_idx, d_got, d_exp} !== {1'b1, 2'd1, 5'd0, 32'h0eed, 32'h0eec}) begin
            mismatched++;
            $display("FAIL value_mismatch_fields: got %h expected %h", {d_done, d_code, d_idx, d_got, d_exp},
                     {1'b1, 2'd1, 5'd0, 32'h0eed, 32'h0eec});
        end
    endtask

    task automatic test_skip();
        logic [111:0] e;
        do_reset(); set_forloop(); load_table();
        q_clear(); push(32'h4, 32'h0eec, 1'b0); push(32'h8, 32'h1, 1'b0); drive_trace();
        e = model(MAIN_TO);
        compared++;
        if (d_vec !== e) begin
            mismatched++; $display("FAIL skip: got %h expected %h", d_vec, e);
        end
        compared++;
        if ({d_done, d_code, d_idx, d_cnt} !== {1'b1, 2'd2, 5'd1, 6'd1}) begin
            mismatched++;
            $display("FAIL skip_fields: got %h expected %h", {d_done, d_code, d_idx, d_cnt},
                     {1'b1, 2'd2, 5'd1, 6'd1});
        end
    endtask

    task automatic test_early_halt();
        logic [111:0] e;
        do_reset(); set_forloop(); load_table();
        q_clear();
        for (int c = 0; c < 10; c++) push(m_num[c], m_ans[c], c == 9);
        drive_trace();
        e = model(MAIN_TO);
        compared++;
        if (d_vec !== e) begin
            mismatched++; $display("FAIL early_halt: got %h expected %h", d_vec, e);
        end
        compared++;
        if ({d_done, d_code, d_idx, d_exp, d_cnt} !== {1'b1, 2'd3, 5'd10, 32'h2, 6'd10}) begin
            mismatched++;
            $display("FAIL early_halt_fields: got %h expected %h", {d_done, d_code, d_idx, d_exp, d_cnt},
                     {1'b1, 2'd3, 5'd10, 32'h2, 6'd10});
        end
    endtask

    task automatic test_timeout();
        logic [111:0] e;
        do_reset(); set_forloop(); load_table();
        q_clear();
        for (int i = 0; i < SHORT_TO - 1; i++) push(32'h0, $urandom, 1'b0);
        drive_trace();
        e = model(SHORT_TO);
        compared++;
        if (t_vec !== e) begin
            mismatched++; $display("FAIL timeout_minus_one: got %h expected %h", t_vec, e);
        end
        do_reset(); load_table();
        push(32'h0, $urandom, 1'b0);
        drive_trace();
        e = model(SHORT_TO);
        compared++;
        if (t_vec !== e) begin
            mismatched++; $display("FAIL timeout: got %h expected %h", t_vec, e);
        end
        compared++;
        if ({t_done, t_tmo, t_code, t_cyc} !== {1'b1, 1'b1, 2'd0, 32'd50}) begin
            mismatched++;
            $display("FAIL timeout_fields: got %h expected %h", {t_done, t_tmo, t_code, t_cyc},
                     {1'b1, 1'b1, 2'd0, 32'd50});
        end
        // restart from verdict; mismatch lands on the timeout cycle
        q_clear();
        for (int i = 0; i < SHORT_TO - 1; i++) push(32'h0, $urandom, 1'b0);
        push(32'h4, 32'h0eed, 1'b0);
        drive_trace();
        e = model(SHORT_TO);
        compared++;
        if (t_vec !== e) begin
            mismatched++; $display("FAIL timeout_vs_mismatch: got %h expected %h", t_vec, e);
        end
        compared++;
        if ({t_done, t_tmo, t_code} !== {1'b1, 1'b0, 2'd1}) begin
            mismatched++;
            $display("FAIL timeout_vs_mismatch_fields: got %h expected %h", {t_done, t_tmo, t_code},
                     {1'b1, 1'b0, 2'd1});
        end
    endtask

    task automatic test_config();
        logic [4:0] errs;
        logic [4:0] want;
        do_reset();
        cfg_write(0, 32'd4, 32'ha);  errs[0] = d_cfg_err;
        cfg_write(1, 32'd3, 32'h0);  errs[1] = d_cfg_err;
        cfg_write(1, 32'd5, 32'hb);  errs[2] = d_cfg_err;
        cfg_write(3, 32'd9, 32'h0);  errs[3] = d_cfg_err;
        cfg_write(2, 32'd7, 32'hc);  errs[4] = d_cfg_err;
        want = 5'b01010;
        compared++;
        if (errs !== want) begin
            mismatched++; $display("FAIL cfg_err_sequence: got %b expected %b", errs, want);
        end
        START = 1'b1; @(posedge CLK); #1; START = 1'b0;
        cfg_write(3, 32'd9, 32'h0);
        compared++;
        if (d_cfg_err !== 1'b0) begin
            mismatched++; $display("FAIL cfg_in_run: got %b expected 0", d_cfg_err);
        end
        q_clear(); push(32'd4, 32'ha, 1'b0); push(32'd5, 32'hb, 1'b0); push(32'd7, 32'hc, 1'b1);
        drive_trace();
        compared++;
        if ({d_done, d_pass, d_code, d_cnt} !== {1'b1, 1'b1, 2'd0, 6'd3}) begin
            mismatched++;
            $display("FAIL cfg_table_run: got %h expected %h", {d_done, d_pass, d_code, d_cnt},
                     {1'b1, 1'b1, 2'd0, 6'd3});
        end
        do_reset(); set_forloop(); load_table();
        compared++;
        if (d_cfg_err !== 1'b0) begin
            mismatched++; $display("FAIL cfg_full_load: got %b expected 0", d_cfg_err);
        end
        cfg_write(17, 32'h50, 32'h0);
        compared++;
        if (d_cfg_err !== 1'b1) begin
            mismatched++; $display("FAIL cfg_overflow: got %b expected 1", d_cfg_err);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [111:0] e;
        do_reset(); set_forloop(); load_table();
        q_clear();
        for (int c = 0; c < 3; c++) push(m_num[c], m_ans[c], 1'b0);
        drive_trace();
        do_reset();
        compared++;
        if ({d_cfg_err, d_vec} !== 113'd0) begin
            mismatched++; $display("FAIL reset_mid_run: got %h expected 0", {d_cfg_err, d_vec});
        end
        m_n = 0;
        q_clear(); push(32'h0, 32'h0, 1'b1); drive_trace();
        e = model(MAIN_TO);
        compared++;
        if (d_vec !== e) begin
            mismatched++; $display("FAIL empty_table_halt: got %h expected %h", d_vec, e);
        end
        compared++;
        if ({d_done, d_pass, d_cnt} !== {1'b1, 1'b1, 6'd0}) begin
            mismatched++;
            $display("FAIL empty_table_fields: got %h expected %h", {d_done, d_pass, d_cnt},
                     {1'b1, 1'b1, 6'd0});
        end
    endtask

    task automatic test_random();
        logic [111:0] e;
        logic [31:0]  acc;
        int           mode, sel;
        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 5);
            m_n  = $urandom_range(1, NT);
            acc  = (it % 3 == 2) ? 32'h7fff_fff0 : 32'h0;
            for (int c = 0; c < m_n; c++) begin
                acc      = acc + 32'($urandom_range(1, 6));
                m_num[c] = acc;
                m_ans[c] = (it % 2 == 0) ? $urandom : 32'($urandom_range(0, 7));
            end
            sel = $urandom_range(0, m_n - 1);
            do_reset(); load_table();
            build_trace(mode, sel); drive_trace();
            e = model(MAIN_TO);
            compared++;
            if (d_vec !== e) begin
                mismatched++;
                $display("FAIL random[%0d] mode %0d sel %0d n %0d: got %h expected %h",
                         it, mode, sel, m_n, d_vec, e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forloop_pass();
        test_value_mismatch();
        test_skip();
        test_early_halt();
        test_timeout();
        test_config();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/riscv_retire_checker.md
Name: riscv_retire_checker

Overview:
- Synthesizable checkpoint checker that sits directly downstream of the RISC-V core and consumes its NUM_INST, OUTPUT_PORT and HALT outputs.
- Holds a table of (instruction count, expected OUTPUT_PORT) checkpoints, loaded through a config port.
- Compares each checkpoint as the core retires, then reports pass, fail or timeout with latched diagnostics.
- Used in the FPGA flow and as the self-checking core of the program benches.

Parameters:
- NUM_TEST, 17, maximum checkpoint entries.
- IDX_W, 5, checkpoint index width; must satisfy 2^IDX_W >= NUM_TEST.
- TIMEOUT_CYCLES, 250000, RUN cycles allowed before a timeout verdict.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
- CFG_WE  in  1  table write strobe; honoured only in IDLE.
- CFG_ADDR  in  IDX_W  table entry index.
- CFG_NUMINST  in  32  checkpoint instruction count.
- CFG_ANS  in  32  expected OUTPUT_PORT value.
- CFG_ERR  out  1  sticky: last write was out of range or non-ascending.
- START  in  1  single-cycle pulse; IDLE -> RUN.
- NUM_INST  in  32  retired instruction count from the core.
- OUTPUT_PORT  in  32  core output port.
- HALT  in  1  core halt indication.
- DONE  out  1  a verdict is held.
- PASS  out  1  every loaded checkpoint matched, then HALT was seen.
- FAIL_CODE  out  2  0 none, 1 value mismatch, 2 checkpoint skipped, 3 HALT with checkpoints pending.
- TIMEOUT  out  1  TIMEOUT_CYCLES elapsed in RUN.
- FAIL_IDX  out  IDX_W  index of the failing checkpoint.
- FAIL_GOT  out  32  OUTPUT_PORT value at failure.
- FAIL_EXP  out  32  expected value at failure.
- PASS_CNT  out  IDX_W+1  checkpoints matched so far.
- CYCLE  out  32  RUN cycle count.

Behaviour:
- Reset: all outputs are 0, state is IDLE, loaded count N is 0, write pointer is 0, table contents are don't-care. RST in any state, including mid-RUN, aborts and returns to IDLE with the table cleared (N=0).
- Config, IDLE only:
  - A CFG_WE write to CFG_ADDR == N, with N < NUM_TEST and (N == 0 or CFG_NUMINST > entry[N-1].numinst), stores the entry, increments N and clears CFG_ERR.
  - Any other CFG_WE in IDLE is dropped and sets CFG_ERR.
  - CFG_WE outside IDLE is ignored and does not set CFG_ERR.
- States: IDLE, RUN, VERDICT.
- IDLE:
  - START -> RUN; ptr=0, CYCLE=0, PASS_CNT=0, all verdict outputs cleared.
  - START with N == 0 still enters RUN; HALT then yields PASS.
- RUN: evaluate once per clock in this priority order. All outputs are registered; a verdict appears on DONE at the edge after the inputs that caused it.
  - (a) If ptr < N and NUM_INST == entry[ptr].numinst:
    - OUTPUT_PORT == ans: ptr++, PASS_CNT++.
    - Otherwise: FAIL_CODE=1, FAIL_IDX=ptr, FAIL_GOT=OUTPUT_PORT, FAIL_EXP=ans, go to VERDICT.
    - A match is consumed once; NUM_INST holding the same value on later cycles is not rechecked because entries are strictly ascending.
  - (b) Else if ptr < N and NUM_INST > entry[ptr].numinst: FAIL_CODE=2, FAIL_IDX=ptr, FAIL_GOT=OUTPUT_PORT, FAIL_EXP=ans, go to VERDICT.
  - (c) HALT, evaluated after (a) in the same cycle, using the post-(a) ptr:
    - ptr == N: PASS=1, go to VERDICT.
    - ptr < N: FAIL_CODE=3, FAIL_IDX=ptr, FAIL_EXP=entry[ptr].ans, FAIL_GOT=OUTPUT_PORT, go to VERDICT.
    - A final-checkpoint match together with HALT in the same cycle gives PASS.
  - (d) CYCLE increments every RUN cycle, saturating at 2^32-1. When CYCLE == TIMEOUT_CYCLES-1 and no other verdict fires this cycle: TIMEOUT=1, go to VERDICT. Any other verdict in that same cycle wins over timeout.
- VERDICT:
  - DONE=1; diagnostics and CYCLE are frozen.
  - Only one of PASS, FAIL_CODE!=0, TIMEOUT is set.
  - START -> RUN with the table retained and verdict outputs cleared. RST -> IDLE.
- Width rules:
  - All comparisons are unsigned 32-bit.
  - PASS_CNT never exceeds N.
  - ptr never indexes at or beyond N; the table read is combinational from a register array indexed by ptr.

Test Plan:
- Load the 17-entry forloop table (4/0x0eec, 6/0x0000, ... 0x46/0x0000), START, drive matching values, HALT at NUM_INST 0x46 -> PASS=1, DONE=1, PASS_CNT=17, FAIL_CODE=0.
- Same table, OUTPUT_PORT=0x0eed at NUM_INST=4 -> next edge DONE=1, FAIL_CODE=1, FAIL_IDX=0, FAIL_GOT=0x0eed, FAIL_EXP=0x0eec.
- NUM_INST jumps 4->8, so entry 1 (count 6) is skipped -> FAIL_CODE=2, FAIL_IDX=1, PASS_CNT=1.
- HALT asserted at NUM_INST 0x16 with 10 of 17 checkpoints matched -> FAIL_CODE=3, FAIL_IDX=10, FAIL_EXP=0x0002.
- TIMEOUT_CYCLES=50, NUM_INST held at 0 -> TIMEOUT=1 with CYCLE=50 exactly 50 cycles after START; a checkpoint mismatch on that same cycle instead gives FAIL_CODE=1, TIMEOUT=0.
- Config and reset: write entry 1 count 3 after entry 0 count 4 -> CFG_ERR=1, N stays 1. Assert RST mid-RUN -> next edge all outputs 0, state IDLE, N=0.
